// File: rtl/pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// pll_lock_ctrl
//
// Acquisition and tracking sequencer that sits between the reference
// correlation low-pass filter and the reference DDS.  It sweeps the DDS
// frequency word from F_START towards F_STOP in F_STEP increments.  After
// every change it waits a settling window so the filter pipeline can flush.
// It then samples the filter's threshold flag ('adjust').  LOCK_CNT
// consecutive hits at one frequency declare lock.  While locked, LOSS_CNT
// consecutive misses drop lock and restart the sweep from F_START.  If a miss
// occurs with no legal frequency left, the sweep parks in FAIL.
//
// Ports
//   clk         in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins acquisition (IDLE/FAIL only)
//   abort       in   one-cycle pulse, returns to IDLE from any state
//   adjust      in   filter flag, 1 = |correlation| >= threshold (hit)
//   freq_word   out  frequency word driven to the DDS
//   freq_upd    out  one-cycle pulse in the cycle freq_word changes
//   locked      out  high in LOCK_SETTLE / LOCK_SAMPLE
//   busy        out  high in every state except IDLE and FAIL
//   sweep_fail  out  high in FAIL
//   lost_lock   out  one-cycle pulse when lock is dropped by misses
//   state_o     out  encoded state (IDLE=0 .. FAIL=5)
// ---------------------------------------------------------------------------
module pll_lock_ctrl #(
   parameter int unsigned   FW         = 32,
   parameter logic [FW-1:0] F_START    = FW'(100),
   parameter logic [FW-1:0] F_STOP     = FW'(150),
   parameter logic [FW-1:0] F_STEP     = FW'(10),
   parameter int unsigned   SETTLE_CYC = 64,
   parameter int unsigned   LOCK_CNT   = 8,
   parameter int unsigned   LOSS_CNT   = 4
) (
   input  logic          clk,
   input  logic          sys_rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          adjust,
   output logic [FW-1:0] freq_word,
   output logic          freq_upd,
   output logic          locked,
   output logic          busy,
   output logic          sweep_fail,
   output logic          lost_lock,
   output logic [2:0]    state_o
);

   // Counter widths.  The settle counter only ever holds SETTLE_CYC-1 down
   // to 0.  The hit/miss counters never exceed LOCK_CNT-1 / LOSS_CNT-1,
   // because reaching the limit changes state in the same edge.
   localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int unsigned HW = $clog2(LOCK_CNT + 1);
   localparam int unsigned MW = $clog2(LOSS_CNT + 1);

   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);
   localparam logic [HW-1:0] HIT_LAST    = HW'(LOCK_CNT - 1);
   localparam logic [MW-1:0] MISS_LAST   = MW'(LOSS_CNT - 1);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_SETTLE      = 3'd1,
      S_SAMPLE      = 3'd2,
      S_LOCK_SETTLE = 3'd3,
      S_LOCK_SAMPLE = 3'd4,
      S_FAIL        = 3'd5
   } state_t;

   state_t        r_state;
   logic [FW-1:0] r_freqWord;
   logic          r_freqUpd;
   logic          r_lostLock;
   logic [HW-1:0] r_hitCnt;
   logic [MW-1:0] r_missCnt;
   logic [SW-1:0] r_settleCnt;

   state_t        w_nextState;
   logic [FW-1:0] w_nextFreq;
   logic          w_nextUpd;
   logic          w_nextLost;
   logic [HW-1:0] w_nextHit;
   logic [MW-1:0] w_nextMiss;
   logic [SW-1:0] w_nextSettle;

   // The step is evaluated one bit wider than the word, so a sweep near the
   // top of the FW range ends in FAIL instead of wrapping to a low frequency.
   logic [FW:0]   w_stepSum;
   logic          w_stepOver;

   assign w_stepSum  = {1'b0, r_freqWord} + {1'b0, F_STEP};
   assign w_stepOver = (w_stepSum > {1'b0, F_STOP});

   // State and datapath registers.  Everything returns to zero on reset,
   // including the frequency word, so the DDS sees a known value.
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_freqWord  <= '0;
         r_freqUpd   <= 1'b0;
         r_lostLock  <= 1'b0;
         r_hitCnt    <= '0;
         r_missCnt   <= '0;
         r_settleCnt <= '0;
      end else begin
         r_state     <= w_nextState;
         r_freqWord  <= w_nextFreq;
         r_freqUpd   <= w_nextUpd;
         r_lostLock  <= w_nextLost;
         r_hitCnt    <= w_nextHit;
         r_missCnt   <= w_nextMiss;
         r_settleCnt <= w_nextSettle;
      end
   end

   // Next-state and datapath decisions.  Abort is checked before anything
   // else, so it wins over start and over any sample result.  An abort keeps
   // the current frequency word and raises no pulses; a held lock is simply
   // cleared and is not reported as lost.
   always_comb begin
      w_nextState  = r_state;
      w_nextFreq   = r_freqWord;
      w_nextUpd    = 1'b0;
      w_nextLost   = 1'b0;
      w_nextHit    = r_hitCnt;
      w_nextMiss   = r_missCnt;
      w_nextSettle = r_settleCnt;

      if (abort) begin
         w_nextState  = S_IDLE;
         w_nextHit    = '0;
         w_nextMiss   = '0;
         w_nextSettle = '0;
      end else begin
         case (r_state)
            S_IDLE, S_FAIL: begin
               if (start) begin
                  w_nextState  = S_SETTLE;
                  w_nextFreq   = F_START;
                  w_nextUpd    = 1'b1;
                  w_nextSettle = SETTLE_LOAD;
                  w_nextHit    = '0;
                  w_nextMiss   = '0;
               end
            end

            // The counter is loaded with SETTLE_CYC-1 on entry.  Leaving on
            // zero gives a window of exactly SETTLE_CYC cycles.
            S_SETTLE: begin
               if (r_settleCnt == '0) begin
                  w_nextState = S_SAMPLE;
               end else begin
                  w_nextSettle = r_settleCnt - SW'(1);
               end
            end

            S_SAMPLE: begin
               w_nextSettle = SETTLE_LOAD;
               if (adjust) begin
                  if (r_hitCnt == HIT_LAST) begin
                     w_nextState = S_LOCK_SETTLE;
                     w_nextMiss  = '0;
                  end else begin
                     // Hit but not enough yet: re-settle at the same word
                     // so every hit is taken on fresh filter output.
                     w_nextState = S_SETTLE;
                     w_nextHit   = r_hitCnt + HW'(1);
                  end
               end else begin
                  w_nextHit = '0;
                  if (w_stepOver) begin
                     w_nextState  = S_FAIL;
                     w_nextSettle = '0;
                  end else begin
                     w_nextState = S_SETTLE;
                     w_nextFreq  = w_stepSum[FW-1:0];
                     w_nextUpd   = 1'b1;
                  end
               end
            end

            S_LOCK_SETTLE: begin
               if (r_settleCnt == '0) begin
                  w_nextState = S_LOCK_SAMPLE;
               end else begin
                  w_nextSettle = r_settleCnt - SW'(1);
               end
            end

            // While locked, only a run of LOSS_CNT misses without an
            // intervening hit drops lock.  The sweep then restarts from the
            // bottom of the range.
            S_LOCK_SAMPLE: begin
               w_nextSettle = SETTLE_LOAD;
               if (adjust) begin
                  w_nextState = S_LOCK_SETTLE;
                  w_nextMiss  = '0;
               end else if (r_missCnt == MISS_LAST) begin
                  w_nextState = S_SETTLE;
                  w_nextLost  = 1'b1;
                  w_nextFreq  = F_START;
                  w_nextUpd   = 1'b1;
                  w_nextHit   = '0;
                  w_nextMiss  = '0;
               end else begin
                  w_nextState = S_LOCK_SETTLE;
                  w_nextMiss  = r_missCnt + MW'(1);
               end
            end

            default: begin
               w_nextState  = S_IDLE;
               w_nextHit    = '0;
               w_nextMiss   = '0;
               w_nextSettle = '0;
            end
         endcase
      end
   end

   // Status flags are decoded from the registered state.  They therefore
   // change on the same edge as the state and clear at once on reset.
   assign freq_word  = r_freqWord;
   assign freq_upd   = r_freqUpd;
   assign lost_lock  = r_lostLock;
   assign locked     = (r_state == S_LOCK_SETTLE) || (r_state == S_LOCK_SAMPLE);
   assign busy       = (r_state != S_IDLE) && (r_state != S_FAIL);
   assign sweep_fail = (r_state == S_FAIL);
   assign state_o    = r_state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_ctrl
//
// Scoreboard bench for pll_lock_ctrl.  The stimulus process advances a
// dwell-level reference model once per cycle.  The model knows when the
// sweep samples, which frequency comes next, and when lock is gained or lost.
// Each output event it predicts (frequency update, lock gained, lock lost,
// sweep failed) is pushed, with its cycle number, into a queue.  A separate
// monitor pops and compares whenever the DUT raises one of those events.
// The stimulus process also compares the steady outputs against the model on
// every cycle.
// ---------------------------------------------------------------------------
module tb_pll_lock_ctrl;

   localparam int FW         = 32;
   localparam int F_START    = 100;
   localparam int F_STOP     = 150;
   localparam int F_STEP     = 10;
   localparam int SETTLE_CYC = 4;
   localparam int LOCK_CNT   = 3;
   localparam int LOSS_CNT   = 2;
   localparam int DWELL      = SETTLE_CYC + 1;

   localparam int EV_UPD  = 0;
   localparam int EV_LOST = 1;
   localparam int EV_LOCK = 2;
   localparam int EV_FAIL = 3;

   typedef struct {
      int     cyc;
      int     kind;
      longint freq;
   } exp_t;

   logic          clk       = 1'b0;
   logic          sys_rst_n = 1'b1;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          adjust    = 1'b0;
   logic [FW-1:0] freq_word;
   logic          freq_upd;
   logic          locked;
   logic          busy;
   logic          sweep_fail;
   logic          lost_lock;
   logic [2:0]    state_o;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t expQ[$];

   // Reference model state, expressed in dwells and samples
   bit     hitScript[$];
   int     hitMode  = 2;
   longint mFreq    = 0;
   bit     mActive  = 1'b0;
   bit     mLocked  = 1'b0;
   bit     mFailed  = 1'b0;
   int     mHits    = 0;
   int     mMisses  = 0;
   int     mNext    = 0;

   pll_lock_ctrl #(
      .FW         (FW),
      .F_START    (32'd100),
      .F_STOP     (32'd150),
      .F_STEP     (32'd10),
      .SETTLE_CYC (SETTLE_CYC),
      .LOCK_CNT   (LOCK_CNT),
      .LOSS_CNT   (LOSS_CNT)
   ) dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .abort      (abort),
      .adjust     (adjust),
      .freq_word  (freq_word),
      .freq_upd   (freq_upd),
      .locked     (locked),
      .busy       (busy),
      .sweep_fail (sweep_fail),
      .lost_lock  (lost_lock),
      .state_o    (state_o)
   );

   // Clock and a cycle counter that names every rising edge
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int c, input int k, input longint f);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.freq = f;
      expQ.push_back(e);
   endtask

   // Compares one observed DUT event with the head of the scoreboard
   task automatic observe(input int kind);
      exp_t e;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL event: got kind=%0d freq=%0d cycle=%0d, required none",
                  kind, freq_word, cyc);
      end else begin
         e = expQ[0];
         expQ.delete(0);
         if (e.kind != kind || e.cyc != cyc || e.freq != longint'(freq_word)) begin
            bad++;
            $display("[TB] FAIL event: got kind=%0d freq=%0d cycle=%0d, required kind=%0d freq=%0d cycle=%0d",
                     kind, freq_word, cyc, e.kind, e.freq, e.cyc);
         end
      end
   endtask

   // Monitor: on the falling edge, look for DUT events and catch overdue
   // expectations that never appeared
   initial begin
      bit prevLocked;
      bit prevFail;
      prevLocked = 1'b0;
      prevFail   = 1'b0;
      forever begin
         @(negedge clk);
         while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            total++;
            bad++;
            $display("[TB] FAIL event: got nothing by cycle %0d, required kind=%0d freq=%0d cycle=%0d",
                     cyc, expQ[0].kind, expQ[0].freq, expQ[0].cyc);
            expQ.delete(0);
         end
         if (lost_lock) observe(EV_LOST);
         if (freq_upd) observe(EV_UPD);
         if (locked && !prevLocked) observe(EV_LOCK);
         if (sweep_fail && !prevFail) observe(EV_FAIL);
         prevLocked = locked;
         prevFail   = sweep_fail;
      end
   end

   function automatic bit pickHit();
      bit b;
      if (hitScript.size() > 0) begin
         b = hitScript[0];
         hitScript.delete(0);
      end else begin
         case (hitMode)
            0:       b = ($urandom_range(0, 1) == 1);
            1:       b = (mFreq == 120);
            3:       b = 1'b1;
            default: b = 1'b0;
         endcase
      end
      return b;
   endfunction

   // One clock of stimulus: check the steady outputs against the model, then
   // drive inputs for the coming edge and advance the model across it.
   // 'adjust' is random on non-sample edges, which the DUT must ignore.
   task automatic applyStimulus(input bit doStart, input bit doAbort);
      int c;
      int expState;
      bit sample;
      bit hit;
      @(negedge clk);
      c = cyc;
      if (!mActive)          expState = mFailed ? 5 : 0;
      else if (c + 1 == mNext) expState = mLocked ? 4 : 2;
      else                   expState = mLocked ? 3 : 1;
      checkOutput("state_o",    longint'(state_o),    longint'(expState));
      checkOutput("freq_word",  longint'(freq_word),  mFreq);
      checkOutput("locked",     longint'(locked),     longint'(mLocked));
      checkOutput("busy",       longint'(busy),       longint'(mActive));
      checkOutput("sweep_fail", longint'(sweep_fail), longint'(mFailed));

      start  = doStart;
      abort  = doAbort;
      sample = mActive && (c + 1 == mNext);
      hit    = sample ? pickHit() : ($urandom_range(0, 1) == 1);
      adjust = hit;

      if (doAbort) begin
         mActive = 1'b0;
         mLocked = 1'b0;
         mFailed = 1'b0;
      end else if (doStart && !mActive) begin
         mActive = 1'b1;
         mFailed = 1'b0;
         mLocked = 1'b0;
         mFreq   = F_START;
         mHits   = 0;
         mMisses = 0;
         mNext   = c + 1 + DWELL;
         push(c + 1, EV_UPD, mFreq);
      end else if (sample) begin
         mNext = c + 1 + DWELL;
         if (!mLocked) begin
            if (hit) begin
               mHits++;
               if (mHits == LOCK_CNT) begin
                  mLocked = 1'b1;
                  mMisses = 0;
                  push(c + 1, EV_LOCK, mFreq);
               end
            end else begin
               mHits = 0;
               if (mFreq + F_STEP > F_STOP) begin
                  mActive = 1'b0;
                  mFailed = 1'b1;
                  push(c + 1, EV_FAIL, mFreq);
               end else begin
                  mFreq = mFreq + F_STEP;
                  push(c + 1, EV_UPD, mFreq);
               end
            end
         end else begin
            if (hit) begin
               mMisses = 0;
            end else begin
               mMisses++;
               if (mMisses == LOSS_CNT) begin
                  mLocked = 1'b0;
                  mHits   = 0;
                  mMisses = 0;
                  mFreq   = F_START;
                  push(c + 1, EV_LOST, mFreq);
                  push(c + 1, EV_UPD, mFreq);
               end
            end
         end
      end
   endtask

   // Asynchronous reset in the middle of a cycle, away from any edge
   task automatic applyReset();
      @(negedge clk);
      #2;
      sys_rst_n = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      #1;
      checkOutput("rst state_o",    longint'(state_o),    0);
      checkOutput("rst freq_word",  longint'(freq_word),  0);
      checkOutput("rst freq_upd",   longint'(freq_upd),   0);
      checkOutput("rst locked",     longint'(locked),     0);
      checkOutput("rst busy",       longint'(busy),       0);
      checkOutput("rst sweep_fail", longint'(sweep_fail), 0);
      checkOutput("rst lost_lock",  longint'(lost_lock),  0);
      mActive = 1'b0;
      mLocked = 1'b0;
      mFailed = 1'b0;
      mFreq   = 0;
      expQ.delete();
      repeat (3) @(negedge clk);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no finish by %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Power-up reset and a quiet idle period without start
      hitMode = 2;
      applyReset();
      repeat (5) applyStimulus(1'b0, 1'b0);

      // Sweep with no hits: 100..150 then FAIL, word held at 150
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 60 && !mFailed; i++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("failRaised", longint'(sweep_fail), 1);
      checkOutput("failFreqHeld", longint'(freq_word), F_STOP);
      repeat (3) applyStimulus(1'b0, 1'b0);

      // Restart from FAIL and lock where only 120 produces hits
      hitMode = 1;
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 80 && !mLocked; i++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("lockedAt120", longint'(locked), 1);
      checkOutput("lockFreq", longint'(freq_word), 120);

      // While locked: one miss is tolerated, two in a row drop lock
      hitMode = 2;
      hitScript.push_back(1'b0);
      hitScript.push_back(1'b1);
      hitScript.push_back(1'b1);
      hitScript.push_back(1'b0);
      hitScript.push_back(1'b0);
      for (int i = 0; i < 40 && hitScript.size() > 0; i++) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("afterLossState", longint'(state_o), 1);
      checkOutput("afterLossFreq", longint'(freq_word), F_START);
      for (int i = 0; i < 60 && !mFailed; i++) applyStimulus(1'b0, 1'b0);

      // Hit, hit, miss at 120 clears the run and steps on
      hitScript.push_back(1'b0);
      hitScript.push_back(1'b0);
      hitScript.push_back(1'b1);
      hitScript.push_back(1'b1);
      hitScript.push_back(1'b0);
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 80 && !mFailed; i++) applyStimulus(1'b0, 1'b0);

      // Abort together with start while settling at 110
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 20 && mFreq != 110; i++) applyStimulus(1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0);
      checkOutput("abortState", longint'(state_o), 0);
      checkOutput("abortBusy", longint'(busy), 0);
      checkOutput("abortFreq", longint'(freq_word), 110);
      applyStimulus(1'b1, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);

      // Abort while locked must not report a lost lock
      hitMode = 3;
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 40 && !mLocked; i++) applyStimulus(1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0);

      // Reset in the middle of a settle window, then stay idle
      hitMode = 2;
      applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b0, 1'b0);
      applyReset();
      repeat (8) applyStimulus(1'b0, 1'b0);

      // Random hits, starts and aborts
      hitMode = 0;
      for (int i = 0; i < 2000; i++) begin
         bit s;
         bit a;
         s = mActive ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 7) == 0);
         a = ($urandom_range(0, 199) == 0);
         applyStimulus(s, a);
      end
      applyStimulus(1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0);
      checkOutput("scoreboardDrained", longint'(expQ.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
